// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: two-flop synchroniser and per-bit debounce for all
// ten switch lines, plus SW[8] edge strobes and an operand snapshot taken on the rise.
module sw_conditioner #(
  parameter int n              = 8,
  parameter int DebounceCycles = 65536
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [9:0]   SWraw,
  output logic [9:0]   SW,
  output logic         SW8Rise,
  output logic         SW8Fall,
  output logic [n-1:0] Data
);

  localparam int            CW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CW-1:0] TERM = CW'(DebounceCycles - 1);

  logic [9:0]    sync1;
  logic [9:0]    sync2;
  logic [CW-1:0] cnt [10];
  logic          prev8;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SWraw;
      sync2 <= sync1;
    end
  end

  // Terminal compare comes before the increment, so a counter never wraps;
  // any return to the accepted level restarts the count from zero.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      SW <= '0;
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (sync2[i] == SW[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TERM) begin
          SW[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // prev8 resets to 0 alongside SW, so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prev8   <= 1'b0;
      SW8Rise <= 1'b0;
      SW8Fall <= 1'b0;
      Data    <= '0;
    end else begin
      prev8   <= SW[8];
      SW8Rise <= SW[8] & ~prev8;
      SW8Fall <= ~SW[8] & prev8;
      if (SW[8] & ~prev8) Data <= SW[n-1:0];
    end
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner (DebounceCycles=4, n=8); strobes are
// scored against a queue of expected {is_rise, data} entries.
module tb_sw_conditioner;

  logic       clk;
  logic       Reset;
  logic [9:0] SWraw;
  logic [9:0] SW;
  logic       SW8Rise;
  logic       SW8Fall;
  logic [7:0] Data;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_seen = 0;
  int fall_seen = 0;
  logic [8:0] exp_q[$];

  sw_conditioner #(.n(8), .DebounceCycles(4)) dut (
    .clk(clk), .Reset(Reset), .SWraw(SWraw), .SW(SW),
    .SW8Rise(SW8Rise), .SW8Fall(SW8Fall), .Data(Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (SW8Rise === 1'b1 || SW8Fall === 1'b1) begin
      logic [8:0] e;
      if (SW8Rise === 1'b1) rise_seen++;
      else fall_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {8'h00, SW8Rise, SW8Fall}, 10'h000);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {8'h00, SW8Rise, SW8Fall}, e[8] ? 10'h002 : 10'h001);
        if (e[8]) chk("captured_data", {2'b00, Data}, {2'b00, e[7:0]});
      end
    end
  end

  initial begin
    int r0, f0;
    Reset = 1'b1;
    SWraw = '0;
    repeat (3) tick();
    chk("reset_sw", SW, 10'h000);
    chk("reset_data", {2'b00, Data}, 10'h000);
    chk("reset_strobes", {8'h00, SW8Rise, SW8Fall}, 10'h000);
    Reset = 1'b0;
    tick();

    // 1. all switches high, then asynchronous reset mid-run
    exp_q.push_back({1'b1, 8'hFF});
    SWraw = 10'h3FF;
    repeat (10) tick();
    chk("all_high_sw", SW, 10'h3FF);
    chk("all_high_data", {2'b00, Data}, 10'h0FF);
    Reset = 1'b1;
    #1;
    chk("async_reset_sw", SW, 10'h000);
    chk("async_reset_data", {2'b00, Data}, 10'h000);
    chk("async_reset_rise", {9'h000, SW8Rise}, 10'h000);
    SWraw = '0;
    tick();
    Reset = 1'b0;
    r0 = rise_seen;
    f0 = fall_seen;
    repeat (10) tick();
    chk("post_reset_no_strobe", 10'(rise_seen - r0 + fall_seen - f0), 10'h000);

    // 2. clean transition latency, both directions
    SWraw[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rise_latency_sw0", {9'h000, SW[0]}, (k == 6) ? 10'h001 : 10'h000);
    end
    SWraw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("fall_latency_sw0", {9'h000, SW[0]}, (k == 6) ? 10'h000 : 10'h001);
    end

    // 3. bounce rejection on bit 3: 3-cycle pulses never reach the count
    for (int p = 0; p < 4; p++) begin
      SWraw[3] = (p % 2 == 0);
      repeat (3) begin
        tick();
        chk("bounce_sw3", {9'h000, SW[3]}, 10'h000);
      end
    end
    SWraw[3] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("settle_sw3", {9'h000, SW[3]}, (k >= 6) ? 10'h001 : 10'h000);
    end

    // 4. handshake capture of A5, operand change while high, then fall
    SWraw[7:0] = 8'hA5;
    repeat (8) tick();
    chk("operand_a5", SW, 10'h0A5);
    exp_q.push_back({1'b1, 8'hA5});
    r0 = rise_seen;
    SWraw[8] = 1'b1;
    repeat (6) tick();
    chk("sw8_up", {9'h000, SW[8]}, 10'h001);
    chk("rise_not_yet", {9'h000, SW8Rise}, 10'h000);
    tick();
    chk("rise_pulse", {9'h000, SW8Rise}, 10'h001);
    chk("data_a5", {2'b00, Data}, 10'h0A5);
    tick();
    chk("rise_one_cycle", {9'h000, SW8Rise}, 10'h000);
    SWraw[7:0] = 8'h3C;
    repeat (8) tick();
    chk("operand_3c", SW[7:0], 10'h03C);
    chk("data_held_a5", {2'b00, Data}, 10'h0A5);
    chk("single_rise", 10'(rise_seen - r0), 10'h001);
    exp_q.push_back({1'b0, 8'h00});
    r0 = rise_seen;
    f0 = fall_seen;
    SWraw[8] = 1'b0;
    repeat (10) tick();
    chk("single_fall", 10'(fall_seen - f0), 10'h001);
    chk("no_rise_on_fall", 10'(rise_seen - r0), 10'h000);

    // 5. re-capture with operand 3C
    exp_q.push_back({1'b1, 8'h3C});
    SWraw[8] = 1'b1;
    repeat (8) tick();
    chk("data_3c", {2'b00, Data}, 10'h03C);
    exp_q.push_back({1'b0, 8'h00});
    SWraw[8] = 1'b0;
    repeat (10) tick();

    // 6. reset two cycles into the SW[8] debounce restarts the count
    SWraw[8] = 1'b1;
    repeat (2) tick();
    Reset = 1'b1;
    #1;
    chk("mid_debounce_reset", SW, 10'h000);
    tick();
    exp_q.push_back({1'b1, 8'h3C});
    r0 = rise_seen;
    Reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("restart_sw8", {9'h000, SW[8]}, (k == 6) ? 10'h001 : 10'h000);
    end
    tick();
    chk("restart_rise", {9'h000, SW8Rise}, 10'h001);
    repeat (6) tick();
    chk("restart_single_rise", 10'(rise_seen - r0), 10'h001);
    chk("queue_drained", 10'(exp_q.size()), 10'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
